csa_accum64: RTL and testbench

Multi-operand 64-bit accumulator controller that sequences the shared carry-save adder (`AddCS64`) and the carry-lookahead adder (`AddLC64`). It accepts a packet of operands over a valid/ready stream and keeps the running total in redundant sum/carry form, adding one operand per cycle. On the last operand it runs a single carry-propagate resolve and presents the 64-bit total on a valid/ready output. It sits between operand producers, such as a multiplier partial-product generator or a reduction engine, and any consumer that needs a resolved sum.

---
 rtl/csa_accum64.sv | 170 +++++++++++++++++
 tb/tb_csa_accum64.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum64.sv
// csa_accum64: multi-operand 64-bit accumulator.
// The running total is kept in carry-save form, with one operand added per
// cycle. The last operand triggers a single carry-lookahead resolve, and the
// resolved total is then offered on a valid/ready output.
// Optional feature macro: CSA_ACCUM_CNT_EN adds the operand counter and the
// out_cnt port.

// 3:2 carry-save adder. Carry bit i has weight 2^(i+1).
module AddCS64 (
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic [63:0] op3,
  output logic [63:0] sum,
  output logic [63:0] carry
);
  assign sum   = op1 ^ op2 ^ op3;
  assign carry = (op1 & op2) | (op1 & op3) | (op2 & op3);
endmodule

// 64-bit carry-lookahead adder: 4-bit lookahead groups, chained group carries.
module AddLC64 (
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  output logic [63:0] sum
);
  logic [63:0] g, p, c;
  logic        cin, grp_g, grp_p;

  assign g = op1 & op2;
  assign p = op1 ^ op2;

  // Expand the carries inside each group, then pass the group carry on.
  always_comb begin
    c     = '0;
    cin   = 1'b0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int k = 0; k < 16; k++) begin
      c[4*k]   = cin;
      c[4*k+1] = g[4*k] | (p[4*k] & cin);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cin);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cin);
      grp_g = g[4*k+3] | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = &p[4*k +: 4];
      cin   = grp_g | (grp_p & cin);
    end
  end

  assign sum = p ^ c;
endmodule

module csa_accum64 #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_sum
`ifdef CSA_ACCUM_CNT_EN
  ,
  output logic [CNT_W-1:0] out_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] acc_s, acc_c;
  logic [63:0] csa_s, csa_c, csa_c_sh, cla_sum;
`ifdef CSA_ACCUM_CNT_EN
  logic [CNT_W-1:0] cnt;
`endif

  AddCS64 u_csa (
    .op1  (acc_s),
    .op2  (acc_c),
    .op3  (in_data),
    .sum  (csa_s),
    .carry(csa_c)
  );

  AddLC64 u_cla (
    .op1(acc_s),
    .op2(acc_c),
    .sum(cla_sum)
  );

  // Shifting the carry into position drops carry[63], which wraps the total
  // modulo 2^64.
  assign csa_c_sh = csa_c << 1;

  // Both handshake flags decode the state register only, so they never
  // depend on in_valid.
  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == OUT);

  // Sequencer: accumulate beats, resolve once, then hold the result until
  // the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc_s   <= '0;
      acc_c   <= '0;
      out_sum <= '0;
`ifdef CSA_ACCUM_CNT_EN
      cnt     <= '0;
      out_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (flush) begin
            // Abort: any beat presented in this cycle is dropped.
            acc_s <= '0;
            acc_c <= '0;
`ifdef CSA_ACCUM_CNT_EN
            cnt   <= '0;
`endif
            state <= IDLE;
          end else if (in_valid) begin
            acc_s <= csa_s;
            acc_c <= csa_c_sh;
`ifdef CSA_ACCUM_CNT_EN
            if (state == IDLE)
              cnt <= CNT_W'(1);
            else if (!(&cnt))
              cnt <= cnt + 1'b1;
`endif
            state <= in_last ? RESOLVE : ACCUM;
          end
        end
        RESOLVE: begin
          out_sum <= cla_sum;
`ifdef CSA_ACCUM_CNT_EN
          out_cnt <= cnt;
`endif
          state   <= OUT;
        end
        OUT: begin
          // A committed result is always delivered, so flush is ignored here.
          if (out_ready) begin
            acc_s <= '0;
            acc_c <= '0;
`ifdef CSA_ACCUM_CNT_EN
            cnt   <= '0;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum64.sv
// Testbench for csa_accum64. An expected-result scoreboard is filled when
// the last beat of a packet is driven and drained when out_valid appears.
`timescale 1ns/1ps

module tb_csa_accum64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_sum;
`ifdef CSA_ACCUM_CNT_EN
  logic [15:0] out_cnt;
`endif

  typedef struct {
    logic [63:0] sum;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  csa_accum64 #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum)
`ifdef CSA_ACCUM_CNT_EN
    ,
    .out_cnt  (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat and return 1 ns after the edge that accepted it.
  task automatic send_beat(input logic [63:0] d, input logic last);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit timed_out);
    int w;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    timed_out = !out_valid;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (out_sum !== 64'h0) begin
      n_fail++; $display("FAIL reset_out_sum: got %h want 0", out_sum);
    end
`ifdef CSA_ACCUM_CNT_EN
    n_checks++;
    if (out_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_out_cnt: got %0d want 0", out_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    out_ready = 1'b1;
    send_beat(64'd1, 1'b0);
    send_beat(64'd2, 1'b0);
    sb.push_back('{sum: 64'd6, cnt: 3});
    send_beat(64'd3, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency_early: out_valid got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency: out_valid got %b want 1", out_valid);
    end
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum) begin
      n_fail++; $display("FAIL basic_sum: got %0d want %0d", out_sum, e.sum);
    end
`ifdef CSA_ACCUM_CNT_EN
    n_checks++;
    if (out_cnt !== 16'(e.cnt)) begin
      n_fail++; $display("FAIL basic_cnt: got %0d want %0d", out_cnt, e.cnt);
    end
`endif
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_handshake: in_ready %b out_valid %b want 1 0",
                         in_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    bit   to;
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    sb.push_back('{sum: 64'd0, cnt: 2});
    send_beat(64'h1, 1'b1);
    wait_out(to);
    e = sb.pop_front();
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL wrap_timeout: out_valid got 0 want 1");
    end else if (out_sum !== e.sum) begin
      n_fail++; $display("FAIL wrap_sum: got %h want %h", out_sum, e.sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    exp_t e;
    bit   to;
    out_ready = 1'b0;
    sb.push_back('{sum: 64'h1234, cnt: 1});
    send_beat(64'h1234, 1'b1);
    wait_out(to);
    e = sb.pop_front();
    n_checks++;
    if (to || out_sum !== e.sum) begin
      n_fail++; $display("FAIL hold_sum: valid %b got %h want %h", out_valid, out_sum, e.sum);
    end
`ifdef CSA_ACCUM_CNT_EN
    n_checks++;
    if (out_cnt !== 16'(e.cnt)) begin
      n_fail++; $display("FAIL hold_cnt: got %0d want %0d", out_cnt, e.cnt);
    end
`endif
    // Flush is raised during the stall; a committed result must survive it.
    for (int i = 0; i < 5; i++) begin
      flush = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== e.sum || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: valid %b sum %h in_ready %b want 1 %h 0",
                 i, out_valid, out_sum, in_ready, e.sum);
      end
    end
    flush = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    exp_t        e;
    bit          to;
    logic [63:0] ref_sum;
    logic [63:0] d;
    ref_sum = '0;
    for (int i = 0; i < 1000; i++) begin
      for (int j = int'($urandom_range(0, 3)); j > 0; j--) begin
        @(posedge clk); #1;
      end
      d = {$urandom, $urandom};
      ref_sum = ref_sum + d;
      if (i == 999) sb.push_back('{sum: ref_sum, cnt: 1000});
      send_beat(d, i == 999);
    end
    wait_out(to);
    e = sb.pop_front();
    n_checks++;
    if (to || out_sum !== e.sum) begin
      n_fail++; $display("FAIL random_sum: valid %b got %h want %h", out_valid, out_sum, e.sum);
    end
`ifdef CSA_ACCUM_CNT_EN
    n_checks++;
    if (out_cnt !== 16'(e.cnt)) begin
      n_fail++; $display("FAIL random_cnt: got %0d want %0d", out_cnt, e.cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    exp_t e;
    bit   to;
    send_beat(64'd5, 1'b0);
    send_beat(64'd7, 1'b0);
    // A beat marked last that arrives together with flush must be dropped.
    in_valid = 1'b1; in_data = 64'd100; in_last = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
    send_beat(64'd9, 1'b0);
    sb.push_back('{sum: 64'd10, cnt: 2});
    send_beat(64'd1, 1'b1);
    wait_out(to);
    e = sb.pop_front();
    n_checks++;
    if (to || out_sum !== e.sum) begin
      n_fail++; $display("FAIL flush_sum: valid %b got %0d want %0d", out_valid, out_sum, e.sum);
    end
`ifdef CSA_ACCUM_CNT_EN
    n_checks++;
    if (out_cnt !== 16'(e.cnt)) begin
      n_fail++; $display("FAIL flush_cnt: got %0d want %0d", out_cnt, e.cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   to;
    send_beat(64'd11, 1'b0);
    send_beat(64'd22, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.push_back('{sum: 64'd4, cnt: 1});
    send_beat(64'd4, 1'b1);
    wait_out(to);
    e = sb.pop_front();
    n_checks++;
    if (to || out_sum !== e.sum) begin
      n_fail++; $display("FAIL rstmid_sum: valid %b got %0d want %0d", out_valid, out_sum, e.sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_pending();
    bit to;
    out_ready = 1'b0;
    send_beat(64'h55, 1'b1);
    wait_out(to);
    rst = 1'b1;
    #1;
    n_checks++;
    if (to || out_valid !== 1'b0 || out_sum !== 64'h0) begin
      n_fail++; $display("FAIL rstpend: timeout %b valid %b sum %h want 0 0 0", to, out_valid, out_sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstpend_after: valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_random();
    test_flush();
    test_reset_mid();
    test_reset_pending();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
